// File: rtl/morse_rx_if.sv
// Morse receiver bus: raw key and soft clear toward the decoder, decoded letter stream back.
interface morse_rx_if;
  logic       key_n;
  logic       clr;
  logic [4:0] code;
  logic       code_valid;
  logic [2:0] sym_cnt;
  logic       busy;
  logic       err;

  modport master (output key_n, clr, input code, code_valid, sym_cnt, busy, err);
  modport slave  (input key_n, clr, output code, code_valid, sym_cnt, busy, err);
endinterface

// File: rtl/morse_rx_decoder.sv
// Morse key receiver: synchronize, debounce, time marks/spaces in units, decode A-Z.
// Define MORSE_RX_WORDGAP_EN to emit a code-30 strobe after a 7-unit release gap.
module morse_rx_decoder #(
  parameter int UNIT_CYCLES     = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic      iCLK,
  input  logic      rst_n,
  morse_rx_if.slave bus
);
  localparam int DIV_W = $clog2(UNIT_CYCLES);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_e;

  logic             sync1_q, sync2_q, key_lvl_q, key_dly_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       dur_q, dur_now;
  logic             tick, mark_rise, mark_fall, mark_edge;

  state_e     state_q, state_d;
  logic [3:0] pattern_q, pattern_d;
  logic [2:0] sym_cnt_q, sym_cnt_d;
  logic       ovf_q, ovf_d;
  logic [4:0] code_q, code_d, letter_code;
  logic       code_valid_q, code_valid_d;
  logic       err_q, err_d;
`ifdef MORSE_RX_WORDGAP_EN
  logic       gap_armed_q, gap_armed_d;
`endif

  function automatic logic [4:0] morse_lookup(input logic [2:0] n, input logic [3:0] p);
    // Key is {symbol count, pattern}; first symbol sits in bit n-1, dash = 1.
    case ({n, p})
      7'b010_0001: morse_lookup = 5'd0;   7'b100_1000: morse_lookup = 5'd1;
      7'b100_1010: morse_lookup = 5'd2;   7'b011_0100: morse_lookup = 5'd3;
      7'b001_0000: morse_lookup = 5'd4;   7'b100_0010: morse_lookup = 5'd5;
      7'b011_0110: morse_lookup = 5'd6;   7'b100_0000: morse_lookup = 5'd7;
      7'b010_0000: morse_lookup = 5'd8;   7'b100_0111: morse_lookup = 5'd9;
      7'b011_0101: morse_lookup = 5'd10;  7'b100_0100: morse_lookup = 5'd11;
      7'b010_0011: morse_lookup = 5'd12;  7'b010_0010: morse_lookup = 5'd13;
      7'b011_0111: morse_lookup = 5'd14;  7'b100_0110: morse_lookup = 5'd15;
      7'b100_1101: morse_lookup = 5'd16;  7'b011_0010: morse_lookup = 5'd17;
      7'b011_0000: morse_lookup = 5'd18;  7'b001_0001: morse_lookup = 5'd19;
      7'b011_0001: morse_lookup = 5'd20;  7'b100_0001: morse_lookup = 5'd21;
      7'b011_0011: morse_lookup = 5'd22;  7'b100_1001: morse_lookup = 5'd23;
      7'b100_1011: morse_lookup = 5'd24;  7'b100_1100: morse_lookup = 5'd25;
      default:     morse_lookup = 5'd31;
    endcase
  endfunction

  // key_lvl_q is the debounced key_n level (1 = released); it flips only after
  // DEBOUNCE_CYCLES consecutive synchronized samples that disagree with it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      key_lvl_q <= 1'b1;
      key_dly_q <= 1'b1;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= bus.key_n;
      sync2_q   <= sync1_q;
      key_dly_q <= key_lvl_q;
      if (sync2_q == key_lvl_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_lvl_q <= sync2_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign mark_rise = key_dly_q & ~key_lvl_q;
  assign mark_fall = ~key_dly_q & key_lvl_q;
  assign mark_edge = mark_rise | mark_fall;
  assign tick      = (div_q == DIV_W'(UNIT_CYCLES - 1));
  // Duration including a tick landing this cycle, so decisions see elapsed whole units.
  assign dur_now   = (tick && dur_q != 3'd7) ? dur_q + 3'd1 : dur_q;

  always_ff @(posedge iCLK) begin
    if (!rst_n || mark_edge) begin
      div_q <= '0;
      dur_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      dur_q <= dur_now;
    end
  end

  assign letter_code = ovf_q ? 5'd31 : morse_lookup(sym_cnt_q, pattern_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    sym_cnt_d    = sym_cnt_q;
    ovf_d        = ovf_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    err_d        = err_q;
`ifdef MORSE_RX_WORDGAP_EN
    gap_armed_d  = gap_armed_q;
`endif
    if (bus.clr) begin
      state_d   = IDLE;
      pattern_d = '0;
      sym_cnt_d = '0;
      ovf_d     = 1'b0;
      err_d     = 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
      gap_armed_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mark_rise) begin
            state_d = MARK;
`ifdef MORSE_RX_WORDGAP_EN
            gap_armed_d = 1'b0;
          end else if (gap_armed_q && dur_now == 3'd7) begin
            code_valid_d = 1'b1;
            code_d       = 5'd30;
            gap_armed_d  = 1'b0;
`endif
          end
        end
        MARK: begin
          if (mark_fall) begin
            state_d = SPACE;
            if (sym_cnt_q == 3'd4) begin
              ovf_d = 1'b1;
            end else begin
              pattern_d = {pattern_q[2:0], dur_now >= 3'd2};
              sym_cnt_d = sym_cnt_q + 3'd1;
            end
          end
        end
        SPACE: begin
          if (dur_now >= 3'd3) begin
            // A press coinciding with letter end starts the next letter instead of being lost.
            state_d      = mark_rise ? MARK : IDLE;
            code_valid_d = 1'b1;
            code_d       = letter_code;
            err_d        = err_q | (letter_code == 5'd31);
            pattern_d    = '0;
            sym_cnt_d    = '0;
            ovf_d        = 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
            gap_armed_d  = ~mark_rise;
`endif
          end else if (mark_rise) begin
            state_d = MARK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pattern_q    <= '0;
      sym_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
      gap_armed_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      sym_cnt_q    <= sym_cnt_d;
      ovf_q        <= ovf_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      err_q        <= err_d;
`ifdef MORSE_RX_WORDGAP_EN
      gap_armed_q  <= gap_armed_d;
`endif
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.sym_cnt    = sym_cnt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_morse_rx_decoder.sv
// Self-checking bench for morse_rx_decoder with UNIT_CYCLES=10, DEBOUNCE_CYCLES=2.
module tb_morse_rx_decoder;
  localparam int UNIT    = 10;
  localparam int DOT     = 10;
  localparam int DASH    = 30;
  localparam int SYM_GAP = 12;
  localparam int LET_GAP = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morse_rx_if bus();

  morse_rx_decoder #(.UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(2)) dut (
    .iCLK  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [4:0] code; logic err; } strobe_t;
  typedef struct { string pat; logic [4:0] code; logic err; } vec_t;

  strobe_t got_q[$];
  strobe_t exp_q[$];
  vec_t    vecs[$];
  int      n_vec  = 0;
  int      n_miss = 0;

  string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  // Every strobe is captured mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) got_q.push_back('{code: bus.code, err: bus.err});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_strobes(input string name);
    check({name, " strobe count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s code[%0d]", name, i), got_q[i].code, exp_q[i].code);
      check($sformatf("%s err[%0d]", name, i), got_q[i].err, exp_q[i].err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic lvl, input int n);
    bus.key_n = lvl;
    step(n);
  endtask

  task automatic send(input string pat, input int tail);
    for (int i = 0; i < pat.len(); i++) begin
      key(1'b0, (pat.getc(i) == "-") ? DASH : DOT);
      key(1'b1, (i == pat.len() - 1) ? tail : SYM_GAP);
    end
  endtask

  function automatic logic [4:0] ref_decode(input string pat);
    ref_decode = 5'd31;
    for (int i = 0; i < 26; i++) if (morse_tab[i] == pat) ref_decode = 5'(i);
  endfunction

  // Reference model works on raw press/release durations: a press of two units or more is
  // a dash, a release of three units or more closes the letter, more than four symbols is invalid.
  task automatic random_run(input int n_seg);
    string      pat;
    logic       err_m;
    logic [4:0] code_m;
    int         p, g;
    pat   = "";
    err_m = 1'b0;
    for (int n = 0; n < n_seg; n++) begin
      p = ($urandom_range(1, 0) == 1) ? $urandom_range(17, 5) : $urandom_range(60, 23);
      if ($urandom_range(9, 0) == 0) p = 80;
      g = ($urandom_range(2, 0) == 0) ? $urandom_range(50, 33) : $urandom_range(26, 5);
      if (n == n_seg - 1) g = LET_GAP;
      key(1'b0, p);
      key(1'b1, g);
      if (p >= 2 * UNIT) pat = {pat, "-"};
      else               pat = {pat, "."};
      if (g >= 3 * UNIT) begin
        code_m = (pat.len() > 4) ? 5'd31 : ref_decode(pat);
        if (code_m == 5'd31) err_m = 1'b1;
        exp_q.push_back('{code: code_m, err: err_m});
        pat = "";
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{pat: ".",     code: 5'd4,  err: 1'b0});
    vecs.push_back('{pat: "-",     code: 5'd19, err: 1'b0});
    vecs.push_back('{pat: "..",    code: 5'd8,  err: 1'b0});
    vecs.push_back('{pat: "--",    code: 5'd12, err: 1'b0});
    vecs.push_back('{pat: "...",   code: 5'd18, err: 1'b0});
    vecs.push_back('{pat: "---",   code: 5'd14, err: 1'b0});
    vecs.push_back('{pat: "....",  code: 5'd7,  err: 1'b0});
    vecs.push_back('{pat: "--..",  code: 5'd25, err: 1'b0});
    vecs.push_back('{pat: "--.-",  code: 5'd16, err: 1'b0});
    vecs.push_back('{pat: "-.--",  code: 5'd24, err: 1'b0});
    vecs.push_back('{pat: "..--",  code: 5'd31, err: 1'b1});
    vecs.push_back('{pat: "-.-.",  code: 5'd2,  err: 1'b1});
    vecs.push_back('{pat: ".....", code: 5'd31, err: 1'b1});

    bus.key_n = 1'b1;
    bus.clr   = 1'b0;
    rst_n     = 1'b0;
    step(5);
    check("reset code", bus.code, 0);
    check("reset code_valid", bus.code_valid, 0);
    check("reset sym_cnt", bus.sym_cnt, 0);
    check("reset busy", bus.busy, 0);
    check("reset err", bus.err, 0);
    rst_n = 1'b1;
    step(5);

    // Letter A with intermediate symbol counts.
    key(1'b0, 10);
    key(1'b1, 8);
    check("A busy in space", bus.busy, 1);
    check("A sym_cnt after dot", bus.sym_cnt, 1);
    key(1'b1, 7);
    key(1'b0, 30);
    key(1'b1, 8);
    check("A sym_cnt after dash", bus.sym_cnt, 2);
    key(1'b1, 32);
    exp_q.push_back('{code: 5'd0, err: 1'b0});
    check_strobes("A");
    check("A sym_cnt after strobe", bus.sym_cnt, 0);
    check("A busy after strobe", bus.busy, 0);
    check("A code held", bus.code, 0);

    foreach (vecs[i]) begin
      send(vecs[i].pat, LET_GAP);
      exp_q.push_back('{code: vecs[i].code, err: vecs[i].err});
      check_strobes({"table ", vecs[i].pat});
    end
    check("code held after invalid", bus.code, 31);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    check("err cleared by clr", bus.err, 0);

    // Single-cycle glitches while released must never enter MARK.
    for (int i = 0; i < 5; i++) begin
      key(1'b0, 1);
      key(1'b1, 3);
      check($sformatf("glitch %0d busy", i), bus.busy, 0);
      key(1'b1, 8);
    end
    step(40);
    check_strobes("glitch");

    // Soft clear during SPACE after two symbols.
    key(1'b0, 10);
    key(1'b1, 15);
    key(1'b0, 30);
    key(1'b1, 8);
    check("clr pre busy", bus.busy, 1);
    check("clr pre sym_cnt", bus.sym_cnt, 2);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    check("clr sym_cnt", bus.sym_cnt, 0);
    check("clr busy", bus.busy, 0);
    step(40);
    check_strobes("clr in space");
    send(".-", LET_GAP);
    exp_q.push_back('{code: 5'd0, err: 1'b0});
    check_strobes("A after clr");

    // Very long mark saturates as a dash.
    key(1'b0, 90);
    key(1'b1, LET_GAP);
    exp_q.push_back('{code: 5'd19, err: 1'b0});
    check_strobes("long mark T");

    // Five dots: count saturates at 4 and the letter is invalid.
    for (int i = 0; i < 5; i++) begin
      key(1'b0, 10);
      key(1'b1, 8);
      check($sformatf("five dots sym_cnt %0d", i), bus.sym_cnt, (i < 4) ? i + 1 : 4);
      key(1'b1, (i == 4) ? 32 : 2);
    end
    exp_q.push_back('{code: 5'd31, err: 1'b1});
    check_strobes("five dots");
    check("five dots err sticky", bus.err, 1);

    // Reset in the middle of a mark discards the letter.
    key(1'b0, 15);
    check("mark busy", bus.busy, 1);
    rst_n     = 1'b0;
    bus.key_n = 1'b1;
    step(1);
    check("mid reset code", bus.code, 0);
    check("mid reset code_valid", bus.code_valid, 0);
    check("mid reset sym_cnt", bus.sym_cnt, 0);
    check("mid reset busy", bus.busy, 0);
    check("mid reset err", bus.err, 0);
    rst_n = 1'b1;
    step(60);
    check_strobes("mid reset");

    // Long release after a letter: word space only when the gap feature is built in.
    send(".-", 80);
    step(100);
    exp_q.push_back('{code: 5'd0, err: 1'b0});
`ifdef MORSE_RX_WORDGAP_EN
    exp_q.push_back('{code: 5'd30, err: 1'b0});
`endif
    check_strobes("word gap");

    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    random_run(120);
    check_strobes("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/morse_rx_decoder.md
MORSE_RX_DECODER -- requirements
Module: morse_rx_decoder

Interface
REQ-001 Parameter UNIT_CYCLES, default 12500000, iCLK cycles per Morse time unit (0.25 s at 50 MHz); legal minimum 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, cycles the synchronized key level must hold stable before acceptance; legal minimum 1.
REQ-003 iCLK  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_n  input  1  raw Morse key (KEY button), asynchronous, low = pressed (mark).
REQ-006 clr  input  1  synchronous soft clear of symbol buffer and err, active-high.
REQ-007 code  output  5  decoded letter: A=0 ... Z=25; 30 = word space; 31 = invalid.
REQ-008 code_valid  output  1  one-cycle strobe qualifying code.
REQ-009 sym_cnt  output  3  symbols buffered in current letter (0-4), for LEDG display.
REQ-010 busy  output  1  high while a letter is in progress (state MARK or SPACE).
REQ-011 err  output  1  sticky; set on invalid letter, cleared by clr or reset.

Function
REQ-012 key_n SHALL pass a 2-flop synchronizer, then a debouncer; the debounced level "mark" changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-013 A unit tick SHALL be generated by a divider counting 0..UNIT_CYCLES-1, restarted on every debounced edge; a duration counter counts ticks, saturating at 7.
REQ-014 FSM states: IDLE, MARK, SPACE.
REQ-015 IDLE: a mark rising edge -> MARK, duration cleared.
REQ-016 MARK: a mark falling edge -> SPACE; symbol = dot if duration < 2 units, dash if >= 2; symbol shifted into the pattern register (dot=0, dash=1, first symbol in MSB of used length); sym_cnt increments.
REQ-017 Fifth symbol: the pattern does not store it; sym_cnt stays 4; an overflow flag is set, forcing code 31 at letter end.
REQ-018 SPACE: a mark rising edge before 3 units -> MARK (same letter); duration reaching 3 units -> letter end: one code_valid cycle, code = International Morse lookup of (sym_cnt, pattern), 31 if no A-Z match or overflow; sym_cnt cleared; -> IDLE.
REQ-019 code_valid SHALL assert exactly 1 cycle after the cycle in which duration reaches 3 in SPACE; code holds its value until the next strobe.
REQ-020 code 31 emission SHALL set err in the same cycle as code_valid.
REQ-021 A mark held >= 7 units is a dash (saturation); no timeout error.
REQ-022 clr in any state SHALL clear pattern, sym_cnt, overflow and err and force IDLE; clr wins over a simultaneous key edge or letter end (no strobe that cycle).

Reset
REQ-023 While rst_n is sampled low: state IDLE, all counters 0, synchronizer and debouncer at released (1), code=0, code_valid=0, sym_cnt=0, busy=0, err=0.
REQ-024 Reset mid-letter SHALL discard the letter with no strobe; the first decode after release requires a fresh debounced press.

Configuration
REQ-025 Macro MORSE_RX_WORDGAP_EN defined: after a letter strobe, if mark stays released until 7 units from the last mark falling edge, one extra strobe with code=30 is emitted; one per gap.
REQ-026 Macro undefined: no word-space strobe; code 30 is never produced; the gap logic is absent.

Verification (UNIT_CYCLES=10, DEBOUNCE_CYCLES=2)
REQ-027 Press 10 cycles, release 15, press 30, release 40 -> one strobe code=0 (A), sym_cnt 1->2->0, err=0.
REQ-028 Four dots (press 10 / gap 10) then release 40 -> code=7 (H); five dots -> code=31, err=1, sym_cnt saturates at 4.
REQ-029 1-cycle glitches on key_n while released -> no MARK entry, busy stays 0, no strobe.
REQ-030 clr pulse during SPACE after 2 symbols -> no strobe, sym_cnt=0, state IDLE; next A decodes correctly.
REQ-031 rst_n low 1 cycle during MARK -> all outputs at reset values the next cycle; with MORSE_RX_WORDGAP_EN, A then 80-cycle release -> strobes code=0 then code=30, exactly one 30.
